// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the dual-slave data memory.
package soc_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } mem_state_e;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_id_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Any latency outside the supported pair collapses to the nearest legal value.
    function automatic int legal_read_lat(input int lat);
        return (lat >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
    endfunction

endpackage

// File: rtl/soc_mem_rr_arb.sv
// Two-requester round-robin arbiter: one-hot grant, pointer favours the port
// that was not granted most recently.
module soc_mem_rr_arb
    import soc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_id_e ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            if (req_i[0] && req_i[1]) begin
                gnt_o = (ptr_q == PORT_S1) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (gnt_o[0]) begin
                ptr_d = PORT_S2;
            end else if (gnt_o[1]) begin
                ptr_d = PORT_S1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PORT_S1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/soc_data_mem_arb.sv
// Dual Avalon-MM slave data memory: round-robin shared single-port RAM,
// pipelined reads and an optional zero-fill sequencer after reset.
module soc_data_mem_arb
    import soc_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 342,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                busy
);

    localparam int NB  = DATA_W / 8;
    localparam int LAT = legal_read_lat(READ_LAT);

    mem_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_we;
    logic                serve;
    logic [1:0]          req, gnt;

    port_id_e            acc_pid;
    logic [ADDR_W-1:0]   acc_addr;
    logic [NB-1:0]       acc_be;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_wr, acc_rd, acc_we, in_range;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                fin_vld;
    port_id_e            fin_pid;
    logic [DATA_W-1:0]   fin_data;
    logic                s1_rvld_q, s2_rvld_q;
    logic [DATA_W-1:0]   s1_rdata_q, s2_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = ~reset;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = SERVE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign serve = (state_q == SERVE) && !reset;
    assign busy  = reset ? (CLEAR_ON_RESET != 0) : (state_q == CLEAR);

    // A read+write request is a write, so it still arbitrates as a request.
    assign req = {s2_chipselect & (s2_read | s2_write),
                  s1_chipselect & (s1_read | s1_write)};

    soc_mem_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (serve),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign s1_waitrequest = ~serve | (req[0] & ~gnt[0]);
    assign s2_waitrequest = ~serve | (req[1] & ~gnt[1]);

    assign acc_pid   = gnt[1] ? PORT_S2 : PORT_S1;
    assign acc_addr  = gnt[1] ? s2_address    : s1_address;
    assign acc_be    = gnt[1] ? s2_byteenable : s1_byteenable;
    assign acc_wdata = gnt[1] ? s2_writedata  : s1_writedata;
    assign acc_wr    = (|gnt) & (gnt[1] ? s2_write : s1_write);
    assign acc_rd    = (|gnt) & ~acc_wr;
    assign in_range  = 32'(acc_addr) < DEPTH;
    assign acc_we    = acc_wr & in_range;
    assign rd_word   = in_range ? mem[acc_addr] : '0;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (acc_we) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_be[b]) begin
                    mem[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Latency 2 inserts one {valid, port, data} stage ahead of the port registers.
    generate
        if (LAT == 2) begin : g_lat2
            logic              vld_q;
            port_id_e          pid_q;
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= acc_rd;
                end
            end

            always_ff @(posedge clk) begin
                pid_q  <= acc_pid;
                data_q <= rd_word;
            end

            assign fin_vld  = vld_q;
            assign fin_pid  = pid_q;
            assign fin_data = data_q;
        end else begin : g_lat1
            assign fin_vld  = acc_rd;
            assign fin_pid  = acc_pid;
            assign fin_data = rd_word;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_rvld_q  <= 1'b0;
            s2_rvld_q  <= 1'b0;
            s1_rdata_q <= '0;
            s2_rdata_q <= '0;
        end else begin
            s1_rvld_q <= fin_vld && (fin_pid == PORT_S1);
            s2_rvld_q <= fin_vld && (fin_pid == PORT_S2);
            if (fin_vld && (fin_pid == PORT_S1)) begin
                s1_rdata_q <= fin_data;
            end
            if (fin_vld && (fin_pid == PORT_S2)) begin
                s2_rdata_q <= fin_data;
            end
        end
    end

    assign s1_readdata      = s1_rdata_q;
    assign s2_readdata      = s2_rdata_q;
    assign s1_readdatavalid = s1_rvld_q;
    assign s2_readdatavalid = s2_rvld_q;

endmodule

// File: tb/tb_soc_data_mem_arb.sv
// Bench for soc_data_mem_arb: two instances (read latency 1 and 2) share one
// stimulus stream and are compared against a transaction-level memory model.
module tb_soc_data_mem_arb;

    localparam int DEPTH = 342;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs [2];
    logic        rd [2];
    logic        wr [2];
    logic [8:0]  addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];

    logic [31:0] rdata [4];
    logic        rvld [4];
    logic        wreq [4];
    logic        busy_w [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        soc_data_mem_arb #(.READ_LAT(d + 1)) u_dut (
            .clk              (clk),
            .reset            (reset),
            .s1_address       (addr[0]),
            .s1_byteenable    (be[0]),
            .s1_chipselect    (cs[0]),
            .s1_read          (rd[0]),
            .s1_write         (wr[0]),
            .s1_writedata     (wd[0]),
            .s1_readdata      (rdata[2*d]),
            .s1_readdatavalid (rvld[2*d]),
            .s1_waitrequest   (wreq[2*d]),
            .s2_address       (addr[1]),
            .s2_byteenable    (be[1]),
            .s2_chipselect    (cs[1]),
            .s2_read          (rd[1]),
            .s2_write         (wr[1]),
            .s2_writedata     (wd[1]),
            .s2_readdata      (rdata[2*d+1]),
            .s2_readdatavalid (rvld[2*d+1]),
            .s2_waitrequest   (wreq[2*d+1]),
            .busy             (busy_w[d])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [0:511];
    int          due_q [4][$];
    logic [31:0] dat_q [4][$];
    logic [31:0] last_rd [4];
    int          pulses [4];
    int          last_gnt;
    bit          lost [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input bit c, input bit r, input bit w,
                         input logic [8:0] a, input logic [3:0] b, input logic [31:0] d);
        cs[p] = c; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic check_outputs();
        bit          ev;
        logic [31:0] ed;
        for (int i = 0; i < 4; i++) begin
            ev = 0;
            if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
                ev = 1;
                ed = dat_q[i].pop_front();
                void'(due_q[i].pop_front());
                last_rd[i] = ed;
            end
            if (rvld[i] === 1'b1) pulses[i]++;
            chk($sformatf("rvalid[lat%0d,s%0d]", i/2 + 1, i%2 + 1), {31'b0, rvld[i]}, {31'b0, ev});
            chk($sformatf("rdata[lat%0d,s%0d]", i/2 + 1, i%2 + 1), rdata[i], last_rd[i]);
        end
        for (int d = 0; d < 2; d++) chk($sformatf("busy_serve[%0d]", d), {31'b0, busy_w[d]}, 32'd0);
    endtask

    // One bus cycle: check waitrequest, apply the access to the model, clock, check outputs.
    task automatic step();
        bit          req [2];
        int          win;
        int          cyc_pre;
        logic [31:0] v;
        #1;
        for (int p = 0; p < 2; p++) req[p] = cs[p] && (rd[p] || wr[p]);
        win = -1;
        if (req[0] && req[1]) win = (last_gnt == 0) ? 1 : 0;
        else if (req[0]) win = 0;
        else if (req[1]) win = 1;
        for (int p = 0; p < 2; p++) begin
            lost[p] = req[p] && (win != p);
            for (int d = 0; d < 2; d++)
                chk($sformatf("waitreq[lat%0d,s%0d]", d + 1, p + 1), {31'b0, wreq[2*d+p]}, {31'b0, lost[p]});
        end
        cyc_pre = cyc;
        if (win >= 0) begin
            last_gnt = win;
            if (wr[win]) begin
                if (addr[win] < DEPTH)
                    for (int b = 0; b < 4; b++)
                        if (be[win][b]) mem_m[addr[win]][8*b +: 8] = wd[win][8*b +: 8];
            end else begin
                v = (addr[win] < DEPTH) ? mem_m[addr[win]] : 32'd0;
                for (int d = 0; d < 2; d++) begin
                    due_q[2*d+win].push_back(cyc_pre + d + 1);
                    dat_q[2*d+win].push_back(v);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        int bc [2];
        reset = 1;
        idle();
        for (int i = 0; i < 4; i++) begin
            due_q[i].delete();
            dat_q[i].delete();
            last_rd[i] = '0;
        end
        last_gnt = 1;
        lost[0] = 0;
        lost[1] = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rst_waitreq[%0d]", i), {31'b0, wreq[i]}, 32'd1);
                chk($sformatf("rst_rvalid[%0d]", i), {31'b0, rvld[i]}, 32'd0);
                chk($sformatf("rst_rdata[%0d]", i), rdata[i], 32'd0);
            end
            for (int d = 0; d < 2; d++) chk($sformatf("rst_busy[%0d]", d), {31'b0, busy_w[d]}, 32'd1);
        end
        reset = 0;
        bc[0] = 0;
        bc[1] = 0;
        for (int k = 0; k < 2000; k++) begin
            #1;
            if (busy_w[0]) bc[0]++;
            if (busy_w[1]) bc[1]++;
            if (!busy_w[0] && !busy_w[1]) break;
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) chk($sformatf("clear_cycles[%0d]", d), bc[d], DEPTH);
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 4; i++) pulses[i] = 0;
    endtask

    initial begin
        bit          c;
        bit          r;
        bit          w;
        logic [8:0]  a;
        logic [31:0] din;

        for (int a2 = 0; a2 < 512; a2++) mem_m[a2] = '0;
        idle();
        clr_pulses();
        @(negedge clk);
        do_reset();

        // Contention straight after reset: grants alternate starting with s1.
        clr_pulses();
        drive(0, 1, 1, 0, 9'd0, 4'hF, '0);
        drive(1, 1, 1, 0, 9'd341, 4'hF, '0);
        repeat (4) step();
        idle();
        repeat (3) step();
        for (int i = 0; i < 4; i++) chk($sformatf("contend_pulses[%0d]", i), pulses[i], 2);

        // Cleared contents.
        drive(0, 1, 1, 0, 9'd0, 4'hF, '0);   step();
        drive(0, 1, 1, 0, 9'd171, 4'hF, '0); step();
        drive(0, 1, 1, 0, 9'd341, 4'hF, '0); step();
        idle();
        repeat (3) step();

        // Byte lanes.
        drive(0, 1, 0, 1, 9'd5, 4'b1111, 32'hAABBCCDD); step();
        drive(0, 1, 0, 1, 9'd5, 4'b0101, 32'h11223344); step();
        idle();
        drive(1, 1, 1, 0, 9'd5, 4'hF, '0); step();
        idle();
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk($sformatf("lanes[%0d]", d), last_rd[2*d+1], 32'hAA22CC44);

        // Out of range write dropped, read returns zero.
        drive(1, 1, 0, 1, 9'd400, 4'hF, 32'hDEADBEEF); step();
        drive(1, 1, 1, 0, 9'd400, 4'hF, '0); step();
        idle();
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk($sformatf("oor_read[%0d]", d), last_rd[2*d+1], 32'd0);
        drive(1, 1, 1, 0, 9'd58, 4'hF, '0); step();
        idle();
        repeat (3) step();

        // Write followed immediately by a read of the same word.
        drive(0, 1, 0, 1, 9'd10, 4'hF, 32'h0BADF00D); step();
        drive(0, 1, 1, 0, 9'd10, 4'hF, '0); step();
        idle();
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk($sformatf("wr_then_rd[%0d]", d), last_rd[2*d], 32'h0BADF00D);

        // 16 distinct words, then 16 back-to-back reads.
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 0, 1, 9'(100 + k), 4'hF, $urandom);
            step();
        end
        clr_pulses();
        for (int k = 0; k < 16; k++) begin
            drive(0, 1, 1, 0, 9'(100 + k), 4'hF, '0);
            step();
        end
        idle();
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk($sformatf("sweep_pulses[%0d]", d), pulses[2*d], 16);

        // Random traffic; a losing port keeps its request unchanged.
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!lost[p]) begin
                    c = ($urandom_range(0, 9) < 7);
                    r = $urandom_range(0, 1);
                    w = ($urandom_range(0, 2) == 0);
                    a = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(DEPTH, 511)) : 9'($urandom_range(0, 31));
                    din = $urandom;
                    drive(p, c, r, w, a, 4'($urandom_range(0, 15)), din);
                end
            end
            step();
        end
        idle();
        repeat (3) step();

        // Reset one cycle after a read is accepted: the latency-2 pulse must vanish.
        drive(0, 1, 1, 0, 9'd10, 4'hF, '0);
        step();
        do_reset();

        // Reset in the middle of a clear restarts the full sequence.
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (50) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("mid_clear_busy[%0d]", d), {31'b0, busy_w[d]}, 32'd1);
        do_reset();
        drive(0, 1, 1, 0, 9'd5, 4'hF, '0); step();
        idle();
        repeat (3) step();
        for (int d = 0; d < 2; d++) chk($sformatf("post_clear_read[%0d]", d), last_rd[2*d], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
